branch_resolve_unit: RTL and testbench

Drives the conditional-PC-write path of the multicycle MIPS datapath. It accepts a branch request from the main control FSM and latches the condition code and target. It waits for the ALU compare to settle, then evaluates the condition from the ALU flags and issues a single-cycle PC write when the branch is taken. It also produces the PCWriteCondMux select consumed by the condition mux, and keeps taken/not-taken statistics counters.

---
 rtl/branch_resolve_unit.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves conditional branches for the multicycle MIPS datapath.
//            Latches the condition code and target when control requests a
//            branch. Waits ALU_LAT cycles for the ALU compare to settle, then
//            evaluates the condition. Issues a one-cycle PC write when the
//            branch is taken, and keeps saturating taken/not-taken counters.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            branch_req            - request strobe (sampled in IDLE only)
//            cond_sel              - 00 !Z, 01 Z, 10 GT, 11 Z|GT
//            branch_target         - target address, latched with request
//            abort                 - cancels a resolution in WAIT/EVAL
//            alu_zero, alu_gt      - ALU flags, valid in EVAL
//            PCWriteCondMux        - latched cond_sel for the condition mux
//            cond_out              - registered evaluated condition
//            pc_write, pc_next     - PC load strobe and value
//            busy, done            - not-IDLE flag, resolution pulse
//            taken_cnt,
//            not_taken_cnt         - saturating statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_req,
  input  logic [1:0]       cond_sel,
  input  logic [31:0]      branch_target,
  input  logic             abort,
  input  logic             alu_zero,
  input  logic             alu_gt,
  output logic [1:0]       PCWriteCondMux,
  output logic             cond_out,
  output logic             pc_write,
  output logic [31:0]      pc_next,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_EVAL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [2:0]       WAIT_INIT = 3'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic [1:0]       sel_q, sel_d;
  logic [31:0]      target_q, target_d;
  logic             cond_q, cond_d;
  logic [31:0]      pc_next_q, pc_next_d;
  logic             pc_write_q, pc_write_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] not_taken_q, not_taken_d;
  logic             w_cond;

  // Condition function selected by the latched code
  always_comb begin
    w_cond = 1'b0;
    case (sel_q)
      2'b00:   w_cond = ~alu_zero;
      2'b01:   w_cond = alu_zero;
      2'b10:   w_cond = alu_gt;
      2'b11:   w_cond = alu_zero | alu_gt;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    target_d    = target_q;
    cond_d      = cond_q;
    pc_next_d   = pc_next_q;
    pc_write_d  = 1'b0;
    done_d      = 1'b0;
    taken_d     = taken_q;
    not_taken_d = not_taken_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE suppresses acceptance for this cycle
        if (branch_req && !abort) begin
          sel_d    = cond_sel;
          target_d = branch_target;
          wait_d   = WAIT_INIT;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wait_q == 3'd0) begin
          state_d = S_EVAL;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      S_EVAL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Strobes are registered here so they are high exactly during
          // the COMMIT cycle.
          cond_d     = w_cond;
          done_d     = 1'b1;
          pc_write_d = w_cond;
          if (w_cond) begin
            pc_next_d = target_q;
          end
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        // abort is deliberately ignored; the commit always completes
        if (cond_q) begin
          if (taken_q != CNT_MAX) begin
            taken_d = taken_q + CNT_ONE;
          end
        end else begin
          if (not_taken_q != CNT_MAX) begin
            not_taken_d = not_taken_q + CNT_ONE;
          end
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 3'd0;
      sel_q       <= 2'b00;
      target_q    <= 32'd0;
      cond_q      <= 1'b0;
      pc_next_q   <= 32'd0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      target_q    <= target_d;
      cond_q      <= cond_d;
      pc_next_q   <= pc_next_d;
      pc_write_q  <= pc_write_d;
      done_q      <= done_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign PCWriteCondMux = sel_q;
  assign cond_out       = cond_q;
  assign pc_write       = pc_write_q;
  assign pc_next        = pc_next_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign taken_cnt      = taken_q;
  assign not_taken_cnt  = not_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit. Three
//            instances share stimulus: A (ALU_LAT=1, CNT_W=16),
//            B (ALU_LAT=4, CNT_W=16) and C (ALU_LAT=1, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        branch_req;
  logic [1:0]  cond_sel;
  logic [31:0] branch_target;
  logic        abort;
  logic        alu_zero;
  logic        alu_gt;

  logic [1:0]  a_mux, b_mux, c_mux;
  logic        a_cond, b_cond, c_cond;
  logic        a_pcw, b_pcw, c_pcw;
  logic [31:0] a_pcn, b_pcn, c_pcn;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic [15:0] a_tk, a_nt, b_tk, b_nt;
  logic [1:0]  c_tk, c_nt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.ALU_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .branch_req(branch_req), .cond_sel(cond_sel),
    .branch_target(branch_target), .abort(abort), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .PCWriteCondMux(a_mux), .cond_out(a_cond),
    .pc_write(a_pcw), .pc_next(a_pcn), .busy(a_busy), .done(a_done),
    .taken_cnt(a_tk), .not_taken_cnt(a_nt));

  branch_resolve_unit #(.ALU_LAT(4), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .branch_req(branch_req), .cond_sel(cond_sel),
    .branch_target(branch_target), .abort(abort), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .PCWriteCondMux(b_mux), .cond_out(b_cond),
    .pc_write(b_pcw), .pc_next(b_pcn), .busy(b_busy), .done(b_done),
    .taken_cnt(b_tk), .not_taken_cnt(b_nt));

  branch_resolve_unit #(.ALU_LAT(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .branch_req(branch_req), .cond_sel(cond_sel),
    .branch_target(branch_target), .abort(abort), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .PCWriteCondMux(c_mux), .cond_out(c_cond),
    .pc_write(c_pcw), .pc_next(c_pcn), .busy(c_busy), .done(c_done),
    .taken_cnt(c_tk), .not_taken_cnt(c_nt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Presents a one-cycle request; returns in the cycle after acceptance
  task automatic issue(input logic [1:0] cs, input logic [31:0] tgt,
                       input logic z, input logic g);
    cond_sel      = cs;
    branch_target = tgt;
    alu_zero      = z;
    alu_gt        = g;
    branch_req    = 1'b1;
    tick();
    branch_req    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_mux, a_cond, a_pcw, a_pcn, a_busy, a_done, a_tk, a_nt} !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs actual=%h expected=0",
               {a_mux, a_cond, a_pcw, a_pcn, a_busy, a_done, a_tk, a_nt});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_taken_zero();
    issue(2'b01, 32'h0040_0020, 1'b1, 1'b0);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL t1_busy actual=%b expected=1", a_busy);
    end
    tick();
    checks++;
    if ({a_done, a_pcw} !== 2'b00) begin
      errors++; $display("FAIL t1_early_done actual=%b expected=00", {a_done, a_pcw});
    end
    tick();
    checks++;
    if ({a_done, a_pcw, a_cond, a_mux, a_pcn} !== {1'b1, 1'b1, 1'b1, 2'b01, 32'h0040_0020}) begin
      errors++;
      $display("FAIL t1_commit actual=%b%b%b %b %h expected=111 01 00400020",
               a_done, a_pcw, a_cond, a_mux, a_pcn);
    end
    tick();
    checks++;
    if ({a_done, a_busy, a_tk, a_nt} !== {1'b0, 1'b0, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL t1_after done=%b busy=%b tk=%0d nt=%0d expected 0 0 1 0",
               a_done, a_busy, a_tk, a_nt);
    end
  endtask

  task automatic test_conditions();
    logic [1:0]  cs_t [3] = '{2'b00, 2'b11, 2'b10};
    logic        z_t  [3] = '{1'b1, 1'b0, 1'b0};
    logic        g_t  [3] = '{1'b0, 1'b1, 1'b0};
    logic        exp_t[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exp_pc = 32'h0040_0020;
    logic [31:0] tgt;
    int          exp_tk = 1;
    int          exp_nt = 0;
    for (int i = 0; i < 3; i++) begin
      tgt = 32'h1000_0000 + 32'(i * 16);
      issue(cs_t[i], tgt, z_t[i], g_t[i]);
      tick();
      tick();
      if (exp_t[i]) begin
        exp_pc = tgt;
        exp_tk++;
      end else begin
        exp_nt++;
      end
      checks++;
      if ({a_done, a_pcw, a_cond, a_mux, a_pcn} !== {1'b1, exp_t[i], exp_t[i], cs_t[i], exp_pc}) begin
        errors++;
        $display("FAIL cond%0d_commit actual=%b%b%b %b %h expected=1%b%b %b %h",
                 i, a_done, a_pcw, a_cond, a_mux, a_pcn, exp_t[i], exp_t[i], cs_t[i], exp_pc);
      end
      tick();
      checks++;
      if ({a_tk, a_nt, a_pcn} !== {16'(exp_tk), 16'(exp_nt), exp_pc}) begin
        errors++;
        $display("FAIL cond%0d_counts tk=%0d nt=%0d pc=%h expected %0d %0d %h",
                 i, a_tk, a_nt, a_pcn, exp_tk, exp_nt, exp_pc);
      end
    end
  endtask

  // Request held high: the COMMIT-cycle request is ignored, IDLE accepts it
  task automatic test_back_to_back();
    int first  = 0;
    int second = 0;
    int n      = 0;
    pulse_reset();
    cond_sel = 2'b01; branch_target = 32'h0000_0100; alu_zero = 1'b1; alu_gt = 1'b0;
    branch_req = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (a_done) begin
        n++;
        if (first == 0) first = i; else second = i;
      end
      if (i == 6) branch_req = 1'b0;
    end
    checks++;
    if (n !== 2 || first !== 2 || second !== 6) begin
      errors++;
      $display("FAIL b2b_timing count=%0d first=%0d second=%0d expected 2 2 6", n, first, second);
    end
    checks++;
    if ({a_tk, a_busy} !== {16'd2, 1'b0}) begin
      errors++; $display("FAIL b2b_counts tk=%0d busy=%b expected 2 0", a_tk, a_busy);
    end
  endtask

  task automatic test_latency4();
    int first = 0;
    int n     = 0;
    pulse_reset();
    issue(2'b01, 32'h0000_4444, 1'b1, 1'b0);
    branch_req = 1'b1;   // second request during WAIT must be dropped
    tick();
    branch_req = 1'b0;
    for (int cyc = 2; cyc < 16; cyc++) begin
      if (b_done) begin
        n++;
        if (first == 0) first = cyc;
      end
      tick();
    end
    checks++;
    if (first !== 6 || n !== 1) begin
      errors++; $display("FAIL lat4_done first=%0d count=%0d expected 6 1", first, n);
    end
    checks++;
    if ({b_tk, b_nt, b_pcn} !== {16'd1, 16'd0, 32'h0000_4444}) begin
      errors++;
      $display("FAIL lat4_counts tk=%0d nt=%0d pc=%h expected 1 0 00004444", b_tk, b_nt, b_pcn);
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    pulse_reset();
    issue(2'b01, 32'h0000_8888, 1'b1, 1'b0);
    abort = 1'b1;        // both A and B are in WAIT here
    tick();
    abort = 1'b0;
    checks++;
    if ({a_busy, b_busy} !== 2'b00) begin
      errors++; $display("FAIL abort_wait_busy actual=%b expected=00", {a_busy, b_busy});
    end
    for (int i = 0; i < 8; i++) begin
      if (a_done || a_pcw || b_done || b_pcw) seen = 1'b1;
      tick();
    end
    checks++;
    if ({seen, a_tk, a_nt, b_tk, b_nt} !== 65'd0) begin
      errors++;
      $display("FAIL abort_wait_effect strobe=%b a=%0d/%0d b=%0d/%0d expected 0 0/0 0/0",
               seen, a_tk, a_nt, b_tk, b_nt);
    end
    // abort during EVAL on A
    issue(2'b01, 32'h0000_9999, 1'b1, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({a_busy, a_done, a_pcw} !== 3'b000) begin
      errors++; $display("FAIL abort_eval actual=%b expected=000", {a_busy, a_done, a_pcw});
    end
    tick();
    tick();
    tick();
    // fresh request resolves normally; abort during COMMIT is ignored
    issue(2'b00, 32'h0000_AAAA, 1'b0, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    checks++;
    if ({a_done, a_pcw, a_pcn} !== {1'b1, 1'b1, 32'h0000_AAAA}) begin
      errors++;
      $display("FAIL abort_new_commit actual=%b%b %h expected=11 0000aaaa", a_done, a_pcw, a_pcn);
    end
    tick();
    abort = 1'b0;
    checks++;
    if ({a_tk, a_nt} !== {16'd1, 16'd0}) begin
      errors++; $display("FAIL abort_commit_count tk=%0d nt=%0d expected 1 0", a_tk, a_nt);
    end
  endtask

  task automatic test_reset_eval();
    issue(2'b11, 32'h0000_BBBB, 1'b0, 1'b1);
    tick();              // A now in EVAL
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({a_mux, a_cond, a_pcw, a_pcn, a_busy, a_done, a_tk, a_nt} !== 70'd0) begin
      errors++;
      $display("FAIL reset_eval actual=%h expected=0",
               {a_mux, a_cond, a_pcw, a_pcn, a_busy, a_done, a_tk, a_nt});
    end
    tick();
    tick();
    checks++;
    if ({a_done, a_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_eval_idle actual=%b expected=00", {a_done, a_busy});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_tk [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      issue(2'b10, 32'h0000_C000, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      checks++;
      if (c_tk !== exp_tk[i]) begin
        errors++; $display("FAIL sat_taken%0d actual=%0d expected=%0d", i, c_tk, exp_tk[i]);
      end
    end
    checks++;
    if (c_nt !== 2'd0) begin
      errors++; $display("FAIL sat_not_taken actual=%0d expected=0", c_nt);
    end
  endtask

  initial begin
    reset = 1'b1; branch_req = 1'b0; cond_sel = 2'b00; branch_target = 32'd0;
    abort = 1'b0; alu_zero = 1'b0; alu_gt = 1'b0;
    test_reset();
    test_taken_zero();
    test_conditions();
    test_back_to_back();
    test_latency4();
    test_abort();
    test_reset_eval();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
